serial_word_assembler: RTL and testbench
========================================

Name: serial_word_assembler

Overview:
- Serial-to-parallel stage directly downstream of the bit-serial FSM stages (for example, the LSB-first copy/invert negator).
- Collects an LSB-first bit stream, framed by a start strobe, into WIDTH-bit words.
- Presents each word on a valid/ready output port.
- Flags framing and overrun errors with sticky status bits. The upstream serial stage has no backpressure, so overruns drop data.

Parameters:
- WIDTH, 8, word width in bits; WIDTH >= 2.
- AUTO_FRAME, 0. If 1, the bit after a completed word starts the next word without needing frame_start. If 0, every word needs frame_start.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bit_in  input  1  serial data bit, LSB first.
- bit_valid  input  1  bit_in is valid this cycle.
- frame_start  input  1  qualifies bit_in as the LSB of a new word. Meaningful only when bit_valid=1.
- word_out  output  WIDTH  assembled word.
- word_valid  output  1  word_out holds a complete word.
- word_ready  input  1  consumer accepts the word when word_valid && word_ready.
- frame_err  output  1  sticky: a frame was cut short by frame_start.
- ovr_err  output  1  sticky: a completed word was dropped because the output register was still occupied.
- clr_err  input  1  synchronous clear of frame_err and ovr_err.

Behaviour:
- Reset (async, rst_n=0):
  - state=S_IDLE, bit count=0, shift register=0.
  - word_out=0, word_valid=0, frame_err=0, ovr_err=0.
- Bit acceptance: a bit is accepted only when bit_valid=1. frame_start with bit_valid=0 is ignored.
- Shift rule: sr <= {bit_in, sr[WIDTH-1:1]}. After WIDTH accepted bits, sr is the word in natural order.
- Bit counter: width $clog2(WIDTH+1). It never exceeds WIDTH.
- S_IDLE:
  - bit_valid && frame_start: accept bit, cnt=1, go to S_COLLECT.
  - bit_valid && !frame_start: bit discarded, no error, stay in S_IDLE.
- S_COLLECT, bit_valid && frame_start before the word completes:
  - Set frame_err.
  - Discard the partial word.
  - This bit becomes the LSB of a new word (cnt=1).
- S_COLLECT, bit_valid && !frame_start: accept bit, cnt+1.
- Word completion: the accepted bit brings cnt to WIDTH. The completed word is {bit_in, sr[WIDTH-1:1]}.
  - If word_valid=0, or word_valid && word_ready in the same cycle: load word_out, word_valid=1 on the next edge. Latency is 1 cycle from the last bit.
  - Otherwise: word dropped, ovr_err set, word_out unchanged.
  - Next state: AUTO_FRAME=0 goes to S_IDLE. AUTO_FRAME=1 stays in S_COLLECT with cnt=0.
  - In both cases a frame_start on the next bit realigns without setting frame_err, because cnt=0.
- Output port:
  - word_valid clears after handshake unless a new word loads in the same cycle.
  - word_out and word_valid are stable while word_valid && !word_ready.
  - word_ready is ignored when word_valid=0.
- Errors:
  - clr_err clears both error bits.
  - If a set and clr_err occur in the same cycle, the set wins.
- Reset mid-frame: partial word lost, all outputs return to reset values immediately (async). No error is flagged after reset.
- Back-to-back words (AUTO_FRAME=1, continuous bit_valid) sustain 1 bit/cycle with no gaps.

Decomposition:
- Shared package serial_pkg:
  - typedef enum logic {S_IDLE, S_COLLECT} asm_state_e.
  - Also used by other serial stages, so all FSMs share state typing.
- One natural sub-module, word_hold_reg:
  - WIDTH-bit output register plus the valid/ready hold logic.
  - Its inputs are a load strobe, the data, and word_ready.
  - It reports busy, which the parent uses for the overrun decision.

Test Plan:
1. WIDTH=8: frame_start on the first bit, bits 1,0,1,0,0,1,0,1 on consecutive cycles, word_ready=1 -> word_out=0xA5 with word_valid=1 for exactly one cycle, the cycle after the 8th bit; no errors.
2. Same stream with word_ready=0 for 5 cycles -> word_out=0xA5 and word_valid=1 held stable for 5 cycles, then cleared 1 cycle after word_ready=1.
3. Word 0x0F completes while 0xA5 is still unacknowledged -> word_out stays 0xA5, ovr_err=1; pulse clr_err -> ovr_err=0.
4. frame_start, then 3 bits, then frame_start with 8 bits of 0x3C -> frame_err=1, word_out=0x3C; no word emitted for the partial frame.
5. AUTO_FRAME=1, 16 continuous bits encoding 0x12 then 0x34, single frame_start -> two words 0x12 and 0x34, 8 cycles apart.
6. rst_n low after 4 bits, release, full frame of 0xFF -> outputs 0 during reset, then word_out=0xFF, no errors; bits before a frame_start are discarded in S_IDLE.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types for the bit-serial pipeline stages.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: asm_state_e, the FSM state type shared by the serial stages.
package serial_pkg;

    typedef enum logic {
        S_IDLE,
        S_COLLECT
    } asm_state_e;

endpackage

// File: rtl/serial_word_assembler_if.sv
// Bundle of the serial input, parallel word output and error/status lines of the word assembler.
// Latency: n/a (wiring only).
// Backpressure: word_ready throttles the word port only; the bit stream itself cannot be stalled.
// Modports: master = bit source / word consumer, slave = assembler.
interface serial_word_assembler_if #(
    parameter int WIDTH = 8
);
    logic             bit_in;
    logic             bit_valid;
    logic             frame_start;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic             frame_err;
    logic             ovr_err;
    logic             clr_err;

    modport master (
        output bit_in, bit_valid, frame_start, word_ready, clr_err,
        input  word_out, word_valid, frame_err, ovr_err
    );

    modport slave (
        input  bit_in, bit_valid, frame_start, word_ready, clr_err,
        output word_out, word_valid, frame_err, ovr_err
    );
endinterface

// File: rtl/word_hold_reg.sv
// Output word register with valid/ready hold behaviour.
// Latency: 1 cycle from load to valid.
// Backpressure: holds dout/valid stable while valid && !word_ready; busy tells the parent a load now would overwrite.
// Ports: load/din (new word), word_ready (consumer), dout/valid (word port), busy (occupied and not leaving).
module word_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             word_ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             busy
);

    // A word leaving this cycle frees the slot for a same-cycle load.
    assign busy = valid && !word_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            dout  <= din;
            valid <= 1'b1;
        end else if (valid && word_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_word_assembler.sv
// Serial-to-parallel assembler: LSB-first bit stream framed by frame_start into WIDTH-bit words.
// Latency: word appears 1 cycle after its last bit is accepted.
// Backpressure: none upstream; a word completing while the output is still occupied is dropped and flags ovr_err.
// Ports: clk, rst_n (async active-low), io (slave modport: bit stream in, word port out, sticky errors + clr_err).
module serial_word_assembler
    import serial_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit AUTO_FRAME = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    serial_word_assembler_if.slave    io
);

    localparam int CW = $clog2(WIDTH + 1);

    asm_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] shifted;
    logic             frame_err_q, ovr_err_q;
    logic             ferr_set, ovr_set;
    logic             load, busy;
    logic             sr_lsb_unused;

    // Bits enter at the top and drift down; after WIDTH bits the LSB sits at bit 0.
    assign shifted = {io.bit_in, sr_q[WIDTH-1:1]};
    // The oldest bit falls off the bottom on every shift.
    assign sr_lsb_unused = sr_q[0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        load     = 1'b0;
        ovr_set  = 1'b0;
        ferr_set = 1'b0;

        if (io.bit_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    // Stray bits outside a frame are dropped silently.
                    if (io.frame_start) begin
                        sr_d    = shifted;
                        cnt_d   = CW'(1);
                        state_d = S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    sr_d = shifted;
                    if (io.frame_start) begin
                        // cnt=0 means a word just finished (auto-framing), so realigning is legal.
                        ferr_set = (cnt_q != '0);
                        cnt_d    = CW'(1);
                    end else if (cnt_q == CW'(WIDTH - 1)) begin
                        load    = !busy;
                        ovr_set = busy;
                        cnt_d   = '0;
                        state_d = AUTO_FRAME ? S_COLLECT : S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
        end
    end

    // Sticky errors; a new error in the clearing cycle survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
            ovr_err_q   <= 1'b0;
        end else begin
            if (ferr_set)        frame_err_q <= 1'b1;
            else if (io.clr_err) frame_err_q <= 1'b0;
            if (ovr_set)         ovr_err_q   <= 1'b1;
            else if (io.clr_err) ovr_err_q   <= 1'b0;
        end
    end

    assign io.frame_err = frame_err_q;
    assign io.ovr_err   = ovr_err_q;

    word_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .din        (shifted),
        .word_ready (io.word_ready),
        .dout       (io.word_out),
        .valid      (io.word_valid),
        .busy       (busy)
    );

endmodule

// File: tb/tb_serial_word_assembler.sv
// Bench for serial_word_assembler: one instance with AUTO_FRAME=0 (dut0), one with AUTO_FRAME=1 (dut1),
// both fed the same stimulus and each compared against a word-level reference model.
module tb_serial_word_assembler;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic bi, bv, fs, rdy, clr;

    serial_word_assembler_if #(.WIDTH(W)) if0 ();
    serial_word_assembler_if #(.WIDTH(W)) if1 ();

    assign if0.bit_in = bi;  assign if0.bit_valid = bv;  assign if0.frame_start = fs;
    assign if0.word_ready = rdy;  assign if0.clr_err = clr;
    assign if1.bit_in = bi;  assign if1.bit_valid = bv;  assign if1.frame_start = fs;
    assign if1.word_ready = rdy;  assign if1.clr_err = clr;

    serial_word_assembler #(.WIDTH(W), .AUTO_FRAME(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .io(if0));
    serial_word_assembler #(.WIDTH(W), .AUTO_FRAME(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .io(if1));

    logic [W-1:0] o_word [2];
    logic         o_vld  [2];
    logic         o_ferr [2];
    logic         o_oerr [2];
    assign o_word[0] = if0.word_out;  assign o_vld[0] = if0.word_valid;
    assign o_ferr[0] = if0.frame_err; assign o_oerr[0] = if0.ovr_err;
    assign o_word[1] = if1.word_out;  assign o_vld[1] = if1.word_valid;
    assign o_ferr[1] = if1.frame_err; assign o_oerr[1] = if1.ovr_err;

    // Reference model: a frame is a running count of received bits plus their numeric value.
    int           m_cnt  [2];
    int           m_acc  [2];
    bit           m_inf  [2];
    logic [W-1:0] m_word [2];
    bit           m_vld  [2];
    bit           m_ferr [2];
    bit           m_oerr [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_acc[k] = 0; m_inf[k] = 1'b0;
            m_word[k] = '0; m_vld[k] = 1'b0; m_ferr[k] = 1'b0; m_oerr[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit complete;
            bit allowed;
            bit fset;
            int word;
            complete = 1'b0; fset = 1'b0; word = 0;
            allowed  = !m_vld[k] || rdy;
            if (bv) begin
                if (fs) begin
                    if (m_inf[k] && m_cnt[k] > 0) fset = 1'b1;
                    m_inf[k] = 1'b1; m_cnt[k] = 1; m_acc[k] = int'(bi);
                end else if (m_inf[k]) begin
                    m_acc[k] = m_acc[k] + (int'(bi) << m_cnt[k]);
                    m_cnt[k] = m_cnt[k] + 1;
                end
                if (m_inf[k] && m_cnt[k] == W) begin
                    complete = 1'b1; word = m_acc[k];
                    m_acc[k] = 0; m_cnt[k] = 0; m_inf[k] = (k == 1);
                end
            end
            if (complete && allowed) begin
                m_word[k] = W'(word); m_vld[k] = 1'b1;
            end else if (m_vld[k] && rdy) begin
                m_vld[k] = 1'b0;
            end
            if (fset) m_ferr[k] = 1'b1;
            else if (clr) m_ferr[k] = 1'b0;
            if (complete && !allowed) m_oerr[k] = 1'b1;
            else if (clr) m_oerr[k] = 1'b0;
        end
    endtask

    // Inputs change at the falling edge; outputs are observed at the next falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive(input logic b, input logic v, input logic f);
        bi = b; bv = v; fs = f;
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit with_fs);
        for (int i = 0; i < W; i++) begin
            drive(w[i], 1'b1, with_fs && (i == 0));
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rdy = 1'b0; clr = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if ({o_word[k], o_vld[k], o_ferr[k], o_oerr[k]} !== 11'b0) begin
                fails++;
                $display("FAIL reset dut%0d: word=%h vld=%b ferr=%b oerr=%b, required all 0",
                         k, o_word[k], o_vld[k], o_ferr[k], o_oerr[k]);
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [W-1:0] w;
        w   = 8'hA5;
        rdy = 1'b1;
        for (int i = 0; i < W; i++) begin
            drive(w[i], 1'b1, i == 0);
            tick();
            if (i < W - 1) begin
                for (int k = 0; k < 2; k++) begin
                    tests++;
                    if (o_vld[k] !== 1'b0) begin
                        fails++;
                        $display("FAIL single_early dut%0d bit%0d: vld=%b, required 0", k, i, o_vld[k]);
                    end
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (o_vld[k] !== 1'b1 || o_word[k] !== 8'hA5 || o_ferr[k] !== 1'b0 || o_oerr[k] !== 1'b0) begin
                fails++;
                $display("FAIL single_word dut%0d: vld=%b word=%h errs=%b%b, required vld=1 word=a5 errs=00",
                         k, o_vld[k], o_word[k], o_ferr[k], o_oerr[k]);
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (o_vld[k] !== 1'b0) begin
                fails++;
                $display("FAIL single_one_cycle dut%0d: vld=%b, required 0", k, o_vld[k]);
            end
        end
    endtask

    task automatic test_hold();
        rdy = 1'b0;
        send_word(8'hA5, 1'b1);
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (o_vld[k] !== 1'b1 || o_word[k] !== 8'hA5) begin
                    fails++;
                    $display("FAIL hold_stable dut%0d cyc%0d: vld=%b word=%h, required vld=1 word=a5",
                             k, c, o_vld[k], o_word[k]);
                end
            end
            tick();
        end
        rdy = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (o_vld[k] !== 1'b0) begin
                fails++;
                $display("FAIL hold_release dut%0d: vld=%b, required 0", k, o_vld[k]);
            end
        end
    endtask

    task automatic test_overrun();
        rdy = 1'b0;
        send_word(8'hA5, 1'b1);
        send_word(8'h0F, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (o_word[k] !== 8'hA5 || o_vld[k] !== 1'b1 || o_oerr[k] !== 1'b1 || o_ferr[k] !== 1'b0) begin
                fails++;
                $display("FAIL overrun dut%0d: word=%h vld=%b oerr=%b ferr=%b, required a5 1 1 0",
                         k, o_word[k], o_vld[k], o_oerr[k], o_ferr[k]);
            end
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (o_oerr[k] !== 1'b0 || o_word[k] !== 8'hA5) begin
                fails++;
                $display("FAIL overrun_clear dut%0d: oerr=%b word=%h, required 0 a5", k, o_oerr[k], o_word[k]);
            end
        end
        rdy = 1'b1;
        tick();
    endtask

    task automatic test_frame_err();
        logic [2:0] part;
        part = 3'b011;
        rdy  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(part[i], 1'b1, i == 0);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (o_vld[k] !== 1'b0 || o_ferr[k] !== 1'b0) begin
                fails++;
                $display("FAIL partial_frame dut%0d: vld=%b ferr=%b, required 0 0", k, o_vld[k], o_ferr[k]);
            end
        end
        send_word(8'h3C, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (o_ferr[k] !== 1'b1 || o_vld[k] !== 1'b1 || o_word[k] !== 8'h3C || o_oerr[k] !== 1'b0) begin
                fails++;
                $display("FAIL frame_err dut%0d: ferr=%b vld=%b word=%h oerr=%b, required 1 1 3c 0",
                         k, o_ferr[k], o_vld[k], o_word[k], o_oerr[k]);
            end
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (o_ferr[k] !== m_ferr[k] || o_ferr[k] !== 1'b0) begin
                fails++;
                $display("FAIL frame_err_clear dut%0d: ferr=%b, required 0", k, o_ferr[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] s;
        logic [W-1:0]   got0 [$];
        logic [W-1:0]   got1 [$];
        int             at1  [$];
        s   = 16'h3412;
        rdy = 1'b1;
        for (int i = 0; i < 2 * W + 2; i++) begin
            if (i < 2 * W) drive(s[i], 1'b1, i == 0);
            else           drive(1'b0, 1'b0, 1'b0);
            tick();
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (o_vld[k] !== m_vld[k] || (o_vld[k] && o_word[k] !== m_word[k])) begin
                    fails++;
                    $display("FAIL b2b_model dut%0d cyc%0d: vld=%b word=%h, required vld=%b word=%h",
                             k, i, o_vld[k], o_word[k], m_vld[k], m_word[k]);
                end
            end
            if (o_vld[0]) got0.push_back(o_word[0]);
            if (o_vld[1]) begin got1.push_back(o_word[1]); at1.push_back(i); end
        end
        tests++;
        if (got1.size() != 2 || got1[0] !== 8'h12 || got1[1] !== 8'h34 || at1[1] - at1[0] != 8) begin
            fails++;
            $display("FAIL b2b_auto: %0d words (first=%h), required 2 words 12,34 spaced 8 cycles",
                     got1.size(), (got1.size() > 0) ? got1[0] : 8'h00);
        end
        tests++;
        if (got0.size() != 1 || got0[0] !== 8'h12) begin
            fails++;
            $display("FAIL b2b_manual: %0d words, required exactly one word 12", got0.size());
        end
    endtask

    task automatic test_reset_mid();
        rdy = 1'b0;
        send_word(8'h5A, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, i == 0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if ({o_word[k], o_vld[k], o_ferr[k], o_oerr[k]} !== 11'b0) begin
                fails++;
                $display("FAIL async_reset dut%0d: word=%h vld=%b ferr=%b oerr=%b, required all 0",
                         k, o_word[k], o_vld[k], o_ferr[k], o_oerr[k]);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            tick();
        end
        send_word(8'hFF, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (o_vld[k] !== 1'b1 || o_word[k] !== 8'hFF || o_ferr[k] !== 1'b0 || o_oerr[k] !== 1'b0) begin
                fails++;
                $display("FAIL after_reset dut%0d: vld=%b word=%h errs=%b%b, required 1 ff 00",
                         k, o_vld[k], o_word[k], o_ferr[k], o_oerr[k]);
            end
        end
        tick();
    endtask

    task automatic test_random();
        int shown;
        shown = 0;
        for (int i = 0; i < 1500; i++) begin
            bv  = ($urandom_range(0, 3) != 0);
            fs  = bv && ($urandom_range(0, 11) == 0);
            bi  = $urandom_range(0, 1) != 0;
            rdy = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 19) == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (o_vld[k] !== m_vld[k] || o_word[k] !== m_word[k] ||
                    o_ferr[k] !== m_ferr[k] || o_oerr[k] !== m_oerr[k]) begin
                    fails++;
                    if (shown < 10) begin
                        shown++;
                        $display("FAIL random dut%0d cyc%0d: vld=%b word=%h ferr=%b oerr=%b, required %b %h %b %b",
                                 k, i, o_vld[k], o_word[k], o_ferr[k], o_oerr[k],
                                 m_vld[k], m_word[k], m_ferr[k], m_oerr[k]);
                    end
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_hold();
        test_overrun();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
